// File: rtl/mem_io_pkg.sv
// Shared constants for the memory/I-O bridge: register offsets inside the
// I/O window and bit positions of the timer control register.
package mem_io_pkg;

    localparam logic [2:0] OFS_OUT   = 3'd0;
    localparam logic [2:0] OFS_IN    = 3'd1;
    localparam logic [2:0] OFS_LOAD  = 3'd2;
    localparam logic [2:0] OFS_CTRL  = 3'd3;
    localparam logic [2:0] OFS_STAT  = 3'd4;
    localparam logic [2:0] OFS_COUNT = 3'd5;

    localparam int CTRL_EN = 0;
    localparam int CTRL_AR = 1;
    localparam int CTRL_IE = 2;

    // True when the upper nibble selects the I/O region.
    function automatic logic is_io(input logic [15:0] addr, input logic [3:0] nibble);
        return (addr[15:12] == nibble);
    endfunction

endpackage

// File: rtl/io_timer.sv
// Prescaled down-counting timer with reload, one-shot/auto-reload modes,
// sticky expiry flag (write-1-to-clear) and a level interrupt.
module io_timer
    import mem_io_pkg::*;
#(
    parameter int PRESCALE = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ctrl_we,
    input  logic [2:0]  ctrl_wdata,
    input  logic        load_we,
    input  logic [15:0] load_wdata,
    input  logic        stat_clr,
    output logic [15:0] load_val,
    output logic [2:0]  ctrl_val,
    output logic [15:0] count_val,
    output logic        flag,
    output logic        irq
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

    logic [PW-1:0] presc_r, presc_s;
    logic [15:0]   count_r, count_s;
    logic [15:0]   load_r, load_s;
    logic [2:0]    ctrl_r, ctrl_s;
    logic          flag_r, flag_s;
    logic          irq_r, irq_s;
    logic          tick_s;

    // Next-state logic; a CTRL write pre-empts any tick on the same edge.
    always_comb begin
        tick_s  = ctrl_r[CTRL_EN] && (presc_r == PRESC_MAX);
        presc_s = presc_r;
        count_s = count_r;
        ctrl_s  = ctrl_r;
        load_s  = load_we ? load_wdata : load_r;
        if (stat_clr) begin
            flag_s = 1'b0;
        end else begin
            flag_s = flag_r;
        end
        if (ctrl_we) begin
            ctrl_s = ctrl_wdata;
            if (ctrl_wdata[CTRL_EN] && !ctrl_r[CTRL_EN]) begin
                count_s = load_r;
                presc_s = '0;
            end else if (!ctrl_wdata[CTRL_EN]) begin
                presc_s = '0;
            end else begin
                presc_s = tick_s ? '0 : presc_r + 1'b1;
            end
        end else if (tick_s) begin
            presc_s = '0;
            if (count_r != 16'd0) begin
                count_s = count_r - 16'd1;
            end else begin
                flag_s = 1'b1;
                if (ctrl_r[CTRL_AR]) begin
                    count_s = load_r;
                end else begin
                    ctrl_s[CTRL_EN] = 1'b0;
                end
            end
        end else if (ctrl_r[CTRL_EN]) begin
            presc_s = presc_r + 1'b1;
        end else begin
            presc_s = '0;
        end
        irq_s = flag_s & ctrl_s[CTRL_IE];
    end

    // Timer state registers, cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_r <= '0;
            count_r <= 16'h0000;
            load_r  <= 16'h0000;
            ctrl_r  <= 3'b000;
            flag_r  <= 1'b0;
            irq_r   <= 1'b0;
        end else begin
            presc_r <= presc_s;
            count_r <= count_s;
            load_r  <= load_s;
            ctrl_r  <= ctrl_s;
            flag_r  <= flag_s;
            irq_r   <= irq_s;
        end
    end

    assign load_val  = load_r;
    assign ctrl_val  = ctrl_r;
    assign count_val = count_r;
    assign flag      = flag_r;
    assign irq       = irq_r;

endmodule

// File: rtl/mem_io_bridge.sv
// Memory-side stage: routes processor accesses to the external data RAM or
// to the memory-mapped output port, synchronized input port and timer.
module mem_io_bridge
    import mem_io_pkg::*;
#(
    parameter int         RAM_AW    = 8,
    parameter logic [3:0] IO_NIBBLE = 4'hF,
    parameter int         PRESCALE  = 50000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mw_en,
    input  logic [15:0]       Address,
    input  logic [15:0]       D_out,
    output logic [15:0]       D_in,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [15:0]       ram_wdata,
    input  logic [15:0]       ram_rdata,
    input  logic [15:0]       in_port,
    output logic [15:0]       out_port,
    output logic              irq
);

    logic        io_sel_s, io_valid_s, io_we_s;
    logic [2:0]  offs_s;
    logic [15:0] io_rdata_s;
    logic [15:0] out_r, sync1_r, sync2_r;
    logic [15:0] load_val_s, count_val_s;
    logic [2:0]  ctrl_val_s;
    logic        flag_s;

    assign io_sel_s   = is_io(Address, IO_NIBBLE);
    assign io_valid_s = io_sel_s && (Address[11:3] == 9'd0);
    assign offs_s     = Address[2:0];
    assign io_we_s    = mw_en & io_valid_s;

    assign ram_we    = mw_en & ~io_sel_s;
    assign ram_addr  = Address[RAM_AW-1:0];
    assign ram_wdata = D_out;

    // Output port register and two-flop input synchronizer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_r   <= 16'h0000;
            sync1_r <= 16'h0000;
            sync2_r <= 16'h0000;
        end else begin
            if (io_we_s && (offs_s == OFS_OUT)) begin
                out_r <= D_out;
            end else begin
                out_r <= out_r;
            end
            sync1_r <= in_port;
            sync2_r <= sync1_r;
        end
    end

    io_timer #(.PRESCALE(PRESCALE)) u_timer (
        .clk        (clk),
        .reset      (reset),
        .ctrl_we    (io_we_s && (offs_s == OFS_CTRL)),
        .ctrl_wdata (D_out[2:0]),
        .load_we    (io_we_s && (offs_s == OFS_LOAD)),
        .load_wdata (D_out),
        .stat_clr   (io_we_s && (offs_s == OFS_STAT) && D_out[0]),
        .load_val   (load_val_s),
        .ctrl_val   (ctrl_val_s),
        .count_val  (count_val_s),
        .flag       (flag_s),
        .irq        (irq)
    );

    // I/O read mux; holes in the window read as zero.
    always_comb begin
        io_rdata_s = 16'h0000;
        if (io_valid_s) begin
            case (offs_s)
                OFS_OUT:   io_rdata_s = out_r;
                OFS_IN:    io_rdata_s = sync2_r;
                OFS_LOAD:  io_rdata_s = load_val_s;
                OFS_CTRL:  io_rdata_s = {13'd0, ctrl_val_s};
                OFS_STAT:  io_rdata_s = {15'd0, flag_s};
                OFS_COUNT: io_rdata_s = count_val_s;
                default:   io_rdata_s = 16'h0000;
            endcase
        end else begin
            io_rdata_s = 16'h0000;
        end
    end

    assign D_in     = io_sel_s ? io_rdata_s : ram_rdata;
    assign out_port = out_r;

endmodule

// File: tb/tb_mem_io_bridge.sv
// Directed self-checking bench for mem_io_bridge with a behavioural RAM.
module tb_mem_io_bridge;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mw_en = 1'b0;
    logic [15:0] Address = 16'h0000;
    logic [15:0] D_out = 16'h0000;
    logic [15:0] D_in;
    logic        ram_we;
    logic [7:0]  ram_addr;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;
    logic [15:0] in_port = 16'h0000;
    logic [15:0] out_port;
    logic        irq;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] ram [0:255];

    mem_io_bridge #(.RAM_AW(8), .IO_NIBBLE(4'hF), .PRESCALE(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .mw_en     (mw_en),
        .Address   (Address),
        .D_out     (D_out),
        .D_in      (D_in),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .in_port   (in_port),
        .out_port  (out_port),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) ram[ram_addr] <= ram_wdata;
    end
    assign ram_rdata = ram[ram_addr];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        Address = a;
        D_out   = d;
        mw_en   = 1'b1;
        @(posedge clk);
        #1;
        mw_en   = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a);
        Address = a;
        mw_en   = 1'b0;
        #1;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        Address = 16'hF005;
        #3;
        chk("rst_out_port", out_port, 16'h0000);
        chk("rst_irq", {15'd0, irq}, 16'h0000);
        chk("rst_count", D_in, 16'h0000);
        chk("rst_ram_we", {15'd0, ram_we}, 16'h0000);
        @(posedge clk);
        #2;
        reset = 1'b1;
        cycles(1);

        // RAM path
        Address = 16'h0012; D_out = 16'hBEEF; mw_en = 1'b1;
        #1;
        chk("ram_we_on", {15'd0, ram_we}, 16'h0001);
        chk("ram_addr", {8'd0, ram_addr}, 16'h0012);
        @(posedge clk);
        #1;
        mw_en = 1'b0;
        #1;
        chk("ram_we_off", {15'd0, ram_we}, 16'h0000);
        rd(16'h0012);
        chk("ram_read", D_in, 16'hBEEF);

        // Output port and aliasing
        Address = 16'hF000; D_out = 16'h00A5; mw_en = 1'b1;
        #1;
        chk("io_no_ram_we", {15'd0, ram_we}, 16'h0000);
        @(posedge clk);
        #1;
        mw_en = 1'b0;
        chk("out_port", out_port, 16'h00A5);
        wr(16'hF008, 16'hFFFF);
        chk("out_alias_ignored", out_port, 16'h00A5);
        rd(16'hF008);
        chk("rd_F008", D_in, 16'h0000);
        rd(16'hF006);
        chk("rd_F006", D_in, 16'h0000);
        rd(16'hF000);
        chk("rd_out", D_in, 16'h00A5);

        // Input synchronizer latency
        rd(16'hF001);
        in_port = 16'h1234;
        cycles(1);
        chk("in_sync_1", D_in, 16'h0000);
        cycles(1);
        chk("in_sync_2", D_in, 16'h1234);
        cycles(1);
        chk("in_sync_3", D_in, 16'h1234);

        // CTRL upper bits read zero, LOAD readback
        wr(16'hF003, 16'hFFF8);
        rd(16'hF003);
        chk("ctrl_hi_zero", D_in, 16'h0000);
        wr(16'hF002, 16'h0003);
        rd(16'hF002);
        chk("load_rb", D_in, 16'h0003);

        // One-shot with irq enabled
        wr(16'hF003, 16'h0005);
        rd(16'hF005);
        chk("os_count3", D_in, 16'h0003);
        cycles(4);
        chk("os_count2", D_in, 16'h0002);
        cycles(4);
        chk("os_count1", D_in, 16'h0001);
        cycles(4);
        chk("os_count0", D_in, 16'h0000);
        rd(16'hF004);
        cycles(3);
        chk("os_flag_pre", D_in, 16'h0000);
        chk("os_irq_pre", {15'd0, irq}, 16'h0000);
        cycles(1);
        chk("os_flag", D_in, 16'h0001);
        chk("os_irq", {15'd0, irq}, 16'h0001);
        rd(16'hF003);
        chk("os_ctrl", D_in, 16'h0004);
        cycles(8);
        rd(16'hF005);
        chk("os_stopped", D_in, 16'h0000);

        // Auto-reload and write-1-to-clear
        wr(16'hF004, 16'h0000);
        rd(16'hF004);
        chk("w0_no_clear", D_in, 16'h0001);
        wr(16'hF004, 16'h0001);
        rd(16'hF004);
        chk("w1c_idle", D_in, 16'h0000);
        wr(16'hF002, 16'h0001);
        wr(16'hF003, 16'h0007);
        rd(16'hF004);
        cycles(7);
        chk("ar_flag_pre", D_in, 16'h0000);
        cycles(1);
        chk("ar_flag_e8", D_in, 16'h0001);
        rd(16'hF005);
        chk("ar_reload", D_in, 16'h0001);
        cycles(7);
        wr(16'hF004, 16'h0001);
        rd(16'hF004);
        chk("w1c_vs_set", D_in, 16'h0001);
        chk("w1c_vs_set_irq", {15'd0, irq}, 16'h0001);
        wr(16'hF004, 16'h0001);
        rd(16'hF004);
        chk("w1c_clear", D_in, 16'h0000);
        chk("w1c_irq", {15'd0, irq}, 16'h0000);
        cycles(7);
        chk("ar_flag_e24", D_in, 16'h0001);

        // Async reset mid-count
        #2;
        reset = 1'b0;
        #1;
        chk("ar_rst_irq", {15'd0, irq}, 16'h0000);
        chk("ar_rst_out", out_port, 16'h0000);
        chk("ar_rst_flag", D_in, 16'h0000);
        rd(16'hF005);
        chk("ar_rst_count", D_in, 16'h0000);
        reset = 1'b1;
        cycles(20);
        chk("post_rst_count", D_in, 16'h0000);
        rd(16'hF003);
        chk("post_rst_ctrl", D_in, 16'h0000);
        rd(16'hF004);
        chk("post_rst_flag", D_in, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
